// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-lane data memory with RV32I sub-word load/store,
// error reporting, a 1-cycle valid/ready request/response path with
// response back-pressure, and an optional post-reset zero-fill sequencer.
module data_memory_lsu #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // RV32I funct3 codes shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_init_cnt;
  logic [31:0]      r_mem [DEPTH];

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_sign;
  size_t            w_size;
  logic             w_misal;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_ofs;
  logic [31:0]      w_word;
  logic [15:0]      w_low;
  logic [31:0]      w_ld_data;
  logic [3:0]       w_be;
  logic [31:0]      w_wlane;
  logic             w_init_wr;

  assign w_idx = req_addr[ADDR_W-1:2];
  assign w_ofs = req_addr[1:0];

  // Handshake outputs are held low while rst_n is asserted so that the
  // reset-time view of the block is quiet regardless of the FSM start state.
  assign req_ready = rst_n && (r_state == S_RUN) && !(r_rsp_valid && !rsp_ready);
  assign init_busy = rst_n && (r_state == S_INIT);
  assign w_accept  = req_valid && req_ready;
  assign w_init_wr = (r_state == S_INIT);

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // FSM state register and zero-fill word counter
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT_ZERO ? S_INIT : S_RUN;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  // Next-state: leave INIT once the last word has been cleared
  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == LAST_IDX) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Decode funct3 into access size, signedness and legality
  always_comb begin
    w_legal = 1'b0;
    w_sign  = 1'b0;
    w_size  = SZ_B;
    case (req_funct3)
      F3_B:  begin w_legal = 1'b1;    w_sign = 1'b1; w_size = SZ_B; end
      F3_H:  begin w_legal = 1'b1;    w_sign = 1'b1; w_size = SZ_H; end
      F3_W:  begin w_legal = 1'b1;                   w_size = SZ_W; end
      F3_BU: begin w_legal = !req_we;                w_size = SZ_B; end
      F3_HU: begin w_legal = !req_we;                w_size = SZ_H; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_misal = ((w_size == SZ_H) && w_ofs[0]) ||
                   ((w_size == SZ_W) && (w_ofs != 2'b00));
  assign w_err   = !w_legal || w_misal;

  // Load path: read the addressed word, align the lane to bit 0, extend
  assign w_word = r_mem[w_idx];
  assign w_low  = 16'(w_word >> {w_ofs, 3'b000});

  always_comb begin
    w_ld_data = '0;
    if (!req_we && !w_err) begin
      case (w_size)
        SZ_B:    w_ld_data = {{24{w_sign & w_low[7]}}, w_low[7:0]};
        SZ_H:    w_ld_data = {{16{w_sign & w_low[15]}}, w_low};
        default: w_ld_data = w_word;
      endcase
    end
  end

  // Store path: replicate store data across lanes and pick the lane enables
  always_comb begin
    w_be    = '0;
    w_wlane = req_wdata;
    if (req_we && !w_err) begin
      case (w_size)
        SZ_B: begin
          w_be    = 4'b0001 << w_ofs;
          w_wlane = {4{req_wdata[7:0]}};
        end
        SZ_H: begin
          w_be    = w_ofs[1] ? 4'b1100 : 4'b0011;
          w_wlane = {2{req_wdata[15:0]}};
        end
        default: w_be = 4'b1111;
      endcase
    end
  end

  // Storage array: zero-fill during INIT, lane-masked stores in RUN
  // NOTE: the array has no reset; clearing it is the INIT sequencer's job, and
  // leaving it out of the reset network lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_init_wr) begin
      r_mem[r_init_cnt] <= '0;
    end else if (w_accept) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wlane[8*l +: 8];
      end
    end
  end

  // Response register: load on accept, drop on consume, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= w_ld_data;
      r_rsp_err   <= w_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed and randomized checks of data_memory_lsu
// against a byte-array reference model of the RV32I load/store rules.
module tb_data_memory_lsu;

  localparam int ADDR_W = 6;
  localparam int NBYTES = 2 ** ADDR_W;
  localparam int NWORDS = NBYTES / 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  data_memory_lsu #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [7:0]  m_mem [NBYTES];
  int          m_init_left = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;

  // Samples taken by the compare step
  bit s_busy;
  bit s_ready;
  bit g_accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one access to the byte-array model
  function automatic void ref_access(input bit we, input logic [2:0] f3, input int addr,
                                     input logic [31:0] wdata,
                                     output logic [31:0] rdata, output bit err);
    int     n;
    bit     sgn;
    bit     legal;
    longint v;
    n = 1; sgn = 1'b0; legal = 1'b1;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: begin n = 1; legal = !we; end
      3'd5: begin n = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    rdata = '0;
    err = !legal || ((addr % n) != 0);
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) m_mem[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(m_mem[addr + i]) << (8 * i));
      if (sgn && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      rdata = 32'(v);
    end
  endfunction

  // One cycle: compare at the falling edge, then advance the model at the rising edge
  task automatic step();
    bit exp_ready;
    logic [31:0] rd;
    bit er;
    @(negedge clk);
    exp_ready = (m_init_left == 0) && !(m_valid && !rsp_ready);
    check("init_busy", 32'(init_busy), 32'(m_init_left > 0));
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    s_busy  = init_busy;
    s_ready = req_ready;
    g_accepted = req_valid && exp_ready;
    @(posedge clk);
    if (m_init_left > 0) begin
      m_init_left--;
    end else if (g_accepted) begin
      ref_access(req_we, req_funct3, int'(req_addr), req_wdata, rd, er);
      m_rdata = rd;
      m_err   = er;
      m_valid = 1'b1;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic issue(input bit we, input logic [2:0] f3, input int addr, input logic [31:0] wdata);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = ADDR_W'(addr);
    req_wdata  = wdata;
    req_valid  = 1'b1;
    g_accepted = 1'b0;
    for (int k = 0; k < 50 && !g_accepted; k++) step();
    if (!g_accepted) begin
      n_checks++;
      n_err++;
      $display("FAIL issue_timeout: got no accept expected accept at %0t", $time);
    end
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input bit we, input logic [2:0] f3, input int addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_er);
    issue(we, f3, addr, wdata);
    check($sformatf("lit_rdata f3=%0d a=%h", f3, addr), rsp_rdata, exp_rd);
    check($sformatf("lit_err f3=%0d a=%h", f3, addr), 32'(rsp_err), 32'(exp_er));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_init_left = NWORDS;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
  endtask

  // Count init_busy cycles until req_ready rises
  task automatic wait_init();
    int busy_cnt;
    int steps;
    busy_cnt = 0;
    steps = 0;
    s_ready = 1'b0;
    for (int i = 0; i < 40 && !s_ready; i++) begin
      step();
      steps++;
      if (s_busy) busy_cnt++;
    end
    check("init_busy_cycles", 32'(busy_cnt), 32'd16);
    check("ready_rise_cycle", 32'(steps), 32'd17);
  endtask

  initial begin
    int addr;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    #2;
    do_reset();
    wait_init();
    expect_rsp(1'b0, 3'd2, 'h3C, 32'h0, 32'h0000_0000, 1'b0);

    // Sign/zero-extended byte loads
    issue(1'b1, 3'd2, 'h10, 32'h80FF7F01);
    expect_rsp(1'b0, 3'd0, 'h10, 32'h0, 32'h0000_0001, 1'b0);
    expect_rsp(1'b0, 3'd0, 'h11, 32'h0, 32'h0000_007F, 1'b0);
    expect_rsp(1'b0, 3'd0, 'h12, 32'h0, 32'hFFFF_FFFF, 1'b0);
    expect_rsp(1'b0, 3'd0, 'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
    expect_rsp(1'b0, 3'd4, 'h13, 32'h0, 32'h0000_0080, 1'b0);

    // Lane-masked sub-word stores
    issue(1'b1, 3'd2, 'h20, 32'h0);
    issue(1'b1, 3'd1, 'h22, 32'h0000BEEF);
    issue(1'b1, 3'd0, 'h20, 32'h0000005A);
    expect_rsp(1'b0, 3'd2, 'h20, 32'h0, 32'hBEEF_005A, 1'b0);
    expect_rsp(1'b0, 3'd1, 'h22, 32'h0, 32'hFFFF_BEEF, 1'b0);
    expect_rsp(1'b0, 3'd5, 'h22, 32'h0, 32'h0000_BEEF, 1'b0);

    // Misaligned and illegal accesses leave the array alone
    issue(1'b1, 3'd2, 'h00, 32'h11223344);
    expect_rsp(1'b1, 3'd2, 'h02, 32'hDEADBEEF, 32'h0, 1'b1);
    expect_rsp(1'b0, 3'd1, 'h01, 32'h0, 32'h0, 1'b1);
    expect_rsp(1'b0, 3'd2, 'h03, 32'h0, 32'h0, 1'b1);
    expect_rsp(1'b0, 3'd3, 'h00, 32'h0, 32'h0, 1'b1);
    expect_rsp(1'b1, 3'd4, 'h00, 32'hCAFEF00D, 32'h0, 1'b1);
    expect_rsp(1'b0, 3'd2, 'h00, 32'h0, 32'h1122_3344, 1'b0);

    // Back-to-back stream, then a 3-cycle stall, then resume
    step();
    for (int i = 0; i < 4; i++) begin
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = ADDR_W'(i * 16);
      step();
      check("stream_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b0;
    req_addr  = ADDR_W'('h24);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", 32'(s_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      addr = $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 3) != 0) addr = addr & ~3;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1);
      req_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      if (!req_we && $urandom_range(0, 2) == 0) req_funct3 = 3'($urandom_range(4, 5));
      req_addr   = ADDR_W'(addr);
      req_wdata  = $urandom;
      rsp_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();

    // Reset while a response is stalled
    rsp_ready = 1'b0;
    issue(1'b0, 3'd2, 'h10, 32'h0);
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    do_reset();
    rsp_ready = 1'b1;
    wait_init();
    expect_rsp(1'b0, 3'd2, 'h00, 32'h0, 32'h0000_0000, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised, byte-lane-organised data memory for the single-cycle/multi-cycle RISC-V cores; successor to the word-only instruction store.
- Adds RV32I sub-word loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) with per-lane write enables and load sign/zero extension.
- Adds misalignment/illegal-funct3 error reporting, a valid/ready request/response handshake with response back-pressure, and an optional post-reset zero-fill sequencer.

Parameters:
- ADDR_W, 10, byte-address width; DEPTH = 2**(ADDR_W-2) words of 32 bits.
- INIT_ZERO, 1, 1 = clear all words after reset before accepting requests; 0 = no clear.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or illegal funct3.
- init_busy  out  1  zero-fill in progress.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=0. FSM goes to INIT if INIT_ZERO=1, else RUN.
- Array contents are not reset asynchronously.
- INIT state:
  - init_busy=1 and req_ready=0.
  - A word counter runs 0..DEPTH-1 and writes 32'h0 to one word per cycle.
  - After writing DEPTH-1, go to RUN. Total: DEPTH cycles.
- RUN state:
  - req_ready = !(rsp_valid && !rsp_ready).
  - A request is accepted on a cycle with req_valid && req_ready.
- Latency: exactly 1. The accepted request's response appears on rsp_valid at the next edge.
- Throughput: with rsp_ready held high, one request per cycle.
- Back-pressure:
  - While rsp_valid && !rsp_ready, rsp_rdata and rsp_err hold stable and no request is accepted.
  - A response is consumed when rsp_valid && rsp_ready.
  - If a new request is accepted in the same cycle, rsp_valid stays 1 with the new data. Otherwise rsp_valid falls to 0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code gives rsp_err=1, rsp_rdata=0, and no write.
- Misalignment:
  - Half-word with addr[0]=1, or word with addr[1:0]!=0, gives rsp_err=1, rsp_rdata=0, and no write.
  - Byte accesses never misalign.
- Stores (when not erroring), written at the accept edge:
  - SB: lane addr[1:0] <= wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0].
  - SW: all four lanes <= wdata.
  - Other lanes are untouched. Response is rsp_rdata=0, rsp_err=0.
- Loads:
  - Read word = array[addr[ADDR_W-1:2]], registered.
  - The word is shifted right by 8*addr[1:0], then sign-extended from bit 7 (LB) or bit 15 (LH), or zero-extended (LBU/LHU). LW returns the word unchanged.
- Ordering: a load accepted the cycle after a store to the same word returns the post-store value (write at edge N, read at edge N+1).
- Reset mid-operation:
  - Pending response is dropped and rsp_valid=0 immediately.
  - The FSM restarts INIT from word 0 when INIT_ZERO=1.
  - A store in flight on the reset edge is not guaranteed to complete.
- Address wrap: not applicable. Every ADDR_W-bit address maps into the array.

Test Plan:
- Reset, then release with INIT_ZERO=1, ADDR_W=6 -> init_busy=1 for exactly 16 cycles, req_ready rises on cycle 17, and LW at 0x3C returns 0x00000000 with rsp_err=0.
- SW 0x80FF7F01 @0x10, then LB @0x10/0x11/0x12/0x13 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. LBU @0x13 -> 0x00000080.
- SW 0x00000000 @0x20, then SH 0xBEEF @0x22, then SB 0x5A @0x20 -> LW @0x20 returns 0xBEEF005A. LH @0x22 returns 0xFFFFBEEF. LHU @0x22 returns 0x0000BEEF.
- Issue, in order, SW @0x02, LH @0x01, LW @0x03, and funct3=011 @0x00 -> each gives rsp_err=1 and rsp_rdata=0. A following LW @0x00 shows the array unchanged.
- Stream 4 back-to-back LWs with rsp_ready=1 -> 4 consecutive rsp_valid cycles, each 1 cycle after its accept.
  - Then drop rsp_ready for 3 cycles -> req_ready=0 and rsp_rdata held for those 3 cycles.
  - Then raise rsp_ready -> stream resumes with no lost or duplicated response.
- Assert rst_n=0 while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 without a clock edge. After release, init_busy=1 restarts the full DEPTH-cycle clear.
